// File: rtl/spmm_out_collector.sv
// Result collector for the SpMM output side: gathers N-element columns into an
// N x N store (optionally accumulating) and drains it RPB rows per beat.
module spmm_out_collector #(
  parameter int unsigned N   = 16,
  parameter int unsigned W   = 8,
  parameter int unsigned RPB = 4,
  localparam int unsigned LGN = $clog2(N)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LGN-1:0]       in_col,
  input  logic [N*W-1:0]       in_data,
  input  logic                 in_last,
  input  logic                 in_os,
  output logic                 out_ready,
  input  logic                 out_start,
  output logic                 out_valid,
  output logic [RPB*N*W-1:0]   out_data
);

  localparam int unsigned NB = N / RPB;
  localparam int unsigned BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {FILL, FULL, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   store [N][N];
  logic [N-1:0]   mask;
  logic [N-1:0]   written;
  logic           os_l;
  logic           os_eff;
  logic [BW-1:0]  beat;
  logic [BW-1:0]  beat_ld;
  logic           accept;
  logic           start_drain;
  logic           last_beat;
  logic           load_beat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= FILL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready    = 1'b0;
    out_ready   = 1'b0;
    accept      = 1'b0;
    start_drain = 1'b0;
    unique case (state)
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && in_last) state_nxt = FULL;
      end
      FULL: begin
        out_ready = 1'b1;
        if (out_start) begin
          start_drain = 1'b1;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        if (last_beat) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  // The first column of a matrix decides the mode before os_l has been latched.
  assign os_eff    = (mask == '0) ? in_os : os_l;
  assign written   = mask | (N'(1) << in_col);
  assign last_beat = (beat == BW'(NB - 1));
  assign load_beat = start_drain | ((state == DRAIN) & ~last_beat);
  assign beat_ld   = start_drain ? '0 : beat + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < N; r++)
        for (int unsigned c = 0; c < N; c++)
          store[LGN'(r)][LGN'(c)] <= '0;
      mask <= '0;
      os_l <= 1'b0;
    end else if (accept) begin
      if (mask == '0) os_l <= in_os;
      // A non-accumulating matrix must not inherit columns it never wrote.
      if (in_last && !os_eff) begin
        for (int unsigned r = 0; r < N; r++)
          for (int unsigned c = 0; c < N; c++)
            if (!written[LGN'(c)]) store[LGN'(r)][LGN'(c)] <= '0;
      end
      for (int unsigned r = 0; r < N; r++)
        store[LGN'(r)][in_col] <= os_eff ? store[LGN'(r)][in_col] + in_data[r*W +: W]
                                         : in_data[r*W +: W];
      mask <= in_last ? '0 : written;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      beat      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= load_beat;
      if (load_beat) begin
        beat <= beat_ld;
        for (int unsigned i = 0; i < RPB; i++)
          for (int unsigned c = 0; c < N; c++)
            out_data[(i*N + c)*W +: W] <= store[LGN'(beat_ld*RPB + i)][LGN'(c)];
      end
    end
  end

endmodule

// File: doc/spmm_out_collector.md
Name: spmm_out_collector

Overview:
- Output-side stage directly downstream of the PE/reduction pipeline in SpMM.
- Captures result columns, one column of N elements per accepted beat, into an N×N result store.
- Optionally accumulates onto the previously stored matrix (output-stationary mode).
- Drains the finished matrix to the SpMM output port at 4 rows per cycle, using the out_ready/out_start handshake.

Parameters:
- N, 16, matrix dimension (power of two, ≥4); LGN = clog2(N).
- W, 8, element width in bits (matches data_t).
- RPB, 4, rows emitted per drain beat; N must be a multiple of RPB.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  a result column is presented.
- in_ready  out  1  collector can accept a column this cycle.
- in_col  in  LGN  column index of in_data.
- in_data  in  N×W  column elements; element r belongs to row r.
- in_last  in  1  this column completes the matrix.
- in_os  in  1  output-stationary: accumulate onto the stored matrix.
- out_ready  out  1  a complete matrix is held and available.
- out_start  in  1  consumer requests drain.
- out_valid  out  1  out_data carries a valid beat.
- out_data  out  RPB×N×W  rows [RPB·k .. RPB·k+RPB-1] on beat k; element [i][c] is row RPB·k+i, column c.

Behaviour:
- Reset (reset=0, async):
  - State goes to FILL.
  - in_ready=1, out_ready=0, out_valid=0, out_data=0.
  - Store cleared to 0, column-written mask cleared, beat counter 0, os latch 0.
- States: FILL, FULL, DRAIN.
- FILL: in_ready=1.
  - A column is accepted on in_valid & in_ready.
  - First accept of a matrix (mask empty) latches os_l <= in_os. The latched value governs the whole matrix; in_os on later columns is ignored.
  - Accept writes column in_col: each element becomes data[r] if os_l=0, or store[r][col]+data[r] if os_l=1. For the first column of a matrix, in_os is used directly in place of os_l.
  - Addition is modulo 2^W (wraps, no saturation).
  - Each accept sets mask[in_col].
  - Same in_col accepted twice in one matrix: the second write applies the same rule again (overwrite when os=0, add again when os=1). No error is flagged.
- Accept with in_last=1: next state FULL; mask cleared.
  - With os_l=0, every column not written in this matrix is zeroed on the in_last transition. The store therefore holds exactly this matrix.
  - With os_l=1, unwritten columns keep their previous values.
- FULL: in_ready=0, out_ready=1.
  - out_start=1 moves to DRAIN next cycle with beat counter 0; out_ready drops the same edge.
- DRAIN: in_ready=0, out_ready=0.
  - Beat k (k = 0 .. N/RPB-1): out_valid=1 and out_data is registered from store rows RPB·k..RPB·k+RPB-1.
  - First beat appears the cycle after out_start is sampled. Beats are consecutive with no stalls.
  - After beat N/RPB-1, next state is FILL and out_valid=0.
  - Drain does not clear the store; it is kept for a subsequent os=1 matrix.
- Latency: in_last accept to out_ready=1 is 1 cycle; out_start to first out_valid is 1 cycle; a full drain takes N/RPB cycles.
- Ignored inputs:
  - in_valid while in_ready=0 is ignored; there is no buffering and upstream must hold.
  - out_start outside FULL is ignored.
  - in_valid with in_last in FILL on the same cycle as out_start is legal; out_start is ignored.
- Outside DRAIN, out_valid=0 and out_data holds its last value. Consumers qualify out_data with out_valid.
- Reset asserted mid-FILL or mid-DRAIN aborts immediately: store and mask zeroed, partial matrix discarded.

Test Plan:
- N=16. Fill columns 0..15 with in_data[r]=r+c, os=0, in_last on column 15 → out_ready=1 one cycle later. Pulse out_start → 4 beats, beat k out_data[i][c]=4k+i+c, then in_ready=1.
- Repeat the same matrix with os=1 → drained values 2·(r+c) mod 256. Then load element 200 with os=1 onto 100 → reads 44 (wrap).
- os=0 matrix writing only columns 3 and 7 (in_last on 7) after a full prior matrix → all other columns drain as 0.
- in_valid held in FULL/DRAIN → in_ready=0, store unchanged. out_start in FILL → no out_valid.
- Reset low during DRAIN beat 2 → out_valid=0 asynchronously. After release: FILL, in_ready=1; a following os=1 matrix accumulates onto zeros.
- Duplicate column 5 in one os=1 matrix, data 1 both times, prior value 10 → drains 12.
